// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
//
// Supervises the 2x125 MHz system PLL from the free-running 50 MHz reference
// clock. It pulses the PLL reset, waits for lock, debounces the lock flag and
// then releases the system reset and raises ready. A lock timeout retries the
// PLL, and a lock loss in RUN restarts the whole sequence. Both events are
// counted, saturating, for debug.
//
// Ports:
//   refclk      in   50 MHz free-running clock (the only clock)
//   rst         in   synchronous active-high reset
//   pll_locked  in   PLL lock flag, asynchronous to refclk
//   pll_rst     out  PLL reset, active high (registered)
//   sys_rst     out  downstream system reset, active high (registered)
//   ready       out  high only in RUN (registered)
//   state       out  FSM state: 0=RESET_PLL 1=WAIT_LOCK 2=STABILIZE 3=RUN
//   loss_count  out  lock losses seen in RUN, saturating
//   retry_count out  lock timeouts, saturating
// ---------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES      = 32'sd16,
    parameter int LOCK_TIMEOUT_CYCLES = 32'sd50000,
    parameter int LOCK_STABLE_CYCLES  = 32'sd1024,
    parameter int CNT_W               = 32'sd16,
    parameter int STAT_W              = 32'sd8
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              pll_locked,
    output logic              pll_rst,
    output logic              sys_rst,
    output logic              ready,
    output logic [1:0]        state,
    output logic [STAT_W-1:0] loss_count,
    output logic [STAT_W-1:0] retry_count
);

    typedef enum logic [1:0] {
        ST_RESET_PLL = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABILIZE = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    // Terminal counts: each state leaves exactly when the counter hits these,
    // so the counter can never wrap.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1'b1);
    localparam logic [STAT_W-1:0] STAT_ZERO   = STAT_W'(1'b0);
    localparam logic [STAT_W-1:0] STAT_ONE    = STAT_W'(1'b1);

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                lock_meta_r;
    logic                lock_sync_r;
    logic                locked_s;
    logic                pll_rst_r;
    logic                sys_rst_r;
    logic                ready_r;
    logic [STAT_W-1:0]   loss_r;
    logic [STAT_W-1:0]   retry_r;

    // Status counters hold at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + STAT_ONE;
        end
    endfunction

    // Output pattern {pll_rst, sys_rst, ready} for the state being entered,
    // so the registered outputs always agree with the state register.
    function automatic logic [2:0] out_decode(input state_t s);
        case (s)
            ST_RESET_PLL: return 3'b110;
            ST_WAIT_LOCK: return 3'b010;
            ST_STABILIZE: return 3'b010;
            ST_RUN:       return 3'b001;
            default:      return 3'b110;
        endcase
    endfunction

    assign locked_s = lock_sync_r;

    // Two-flop synchroniser bringing the asynchronous lock flag into refclk.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= pll_locked;
            lock_sync_r <= lock_meta_r;
        end
    end

    // Supervisor FSM with its cycle counter, status counters and outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_r                        <= ST_RESET_PLL;
            cnt_r                          <= CNT_ZERO;
            {pll_rst_r, sys_rst_r, ready_r} <= out_decode(ST_RESET_PLL);
            loss_r                         <= STAT_ZERO;
            retry_r                        <= STAT_ZERO;
        end else begin
            case (state_r)
                // Lock flag is deliberately ignored while the PLL is held in reset.
                ST_RESET_PLL: begin
                    if (cnt_r == RST_LAST) begin
                        state_r                        <= ST_WAIT_LOCK;
                        cnt_r                          <= CNT_ZERO;
                        {pll_rst_r, sys_rst_r, ready_r} <= out_decode(ST_WAIT_LOCK);
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_r                        <= ST_STABILIZE;
                        cnt_r                          <= CNT_ZERO;
                        {pll_rst_r, sys_rst_r, ready_r} <= out_decode(ST_STABILIZE);
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        state_r                        <= ST_RESET_PLL;
                        cnt_r                          <= CNT_ZERO;
                        {pll_rst_r, sys_rst_r, ready_r} <= out_decode(ST_RESET_PLL);
                        retry_r                        <= sat_inc(retry_r);
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                // A dropout here only restarts the debounce; lock drop wins
                // even on the terminal count.
                ST_STABILIZE: begin
                    if (!locked_s) begin
                        state_r                        <= ST_WAIT_LOCK;
                        cnt_r                          <= CNT_ZERO;
                        {pll_rst_r, sys_rst_r, ready_r} <= out_decode(ST_WAIT_LOCK);
                    end else if (cnt_r == STABLE_LAST) begin
                        state_r                        <= ST_RUN;
                        cnt_r                          <= CNT_ZERO;
                        {pll_rst_r, sys_rst_r, ready_r} <= out_decode(ST_RUN);
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                // Any single low cycle of the synchronised flag is a loss.
                ST_RUN: begin
                    if (!locked_s) begin
                        state_r                        <= ST_RESET_PLL;
                        cnt_r                          <= CNT_ZERO;
                        {pll_rst_r, sys_rst_r, ready_r} <= out_decode(ST_RESET_PLL);
                        loss_r                         <= sat_inc(loss_r);
                    end else begin
                        cnt_r <= CNT_ZERO;
                    end
                end
                default: begin
                    state_r                        <= ST_RESET_PLL;
                    cnt_r                          <= CNT_ZERO;
                    {pll_rst_r, sys_rst_r, ready_r} <= out_decode(ST_RESET_PLL);
                end
            endcase
        end
    end

    assign state       = state_r;
    assign pll_rst     = pll_rst_r;
    assign sys_rst     = sys_rst_r;
    assign ready       = ready_r;
    assign loss_count  = loss_r;
    assign retry_count = retry_r;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_supervisor
//
// Directed bench for pll_lock_supervisor with small cycle parameters
// (4 / 20 / 8, STAT_W=2). Each scenario task drives the inputs one cycle at a
// time and compares the packed output vector
// {state, pll_rst, sys_rst, ready, loss_count, retry_count} against values
// worked out by hand from the edge count since the stimulus change.
// ---------------------------------------------------------------------------
module tb_pll_lock_supervisor;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [1:0] state;
    logic [1:0] loss_count;
    logic [1:0] retry_count;
    logic [8:0] act;

    int n_vec;
    int n_err;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES      (4),
        .LOCK_TIMEOUT_CYCLES (20),
        .LOCK_STABLE_CYCLES  (8),
        .CNT_W               (16),
        .STAT_W              (2)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .state       (state),
        .loss_count  (loss_count),
        .retry_count (retry_count)
    );

    assign act = {state, pll_rst, sys_rst, ready, loss_count, retry_count};

    // 50 MHz reference clock.
    initial begin
        refclk = 1'b0;
        forever #10 refclk = ~refclk;
    end

    // Expected packed outputs for a state and the two counts.
    function automatic logic [8:0] exp_vec(input logic [1:0] st, input logic [1:0] lc,
                                           input logic [1:0] rc);
        return {st, (st == 2'd0), (st != 2'd3), (st == 2'd3), lc, rc};
    endfunction

    // Advance one refclk edge and settle 1 ns past it.
    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] exp;
        rst        = 1'b1;
        pll_locked = 1'b0;
        for (int i = 0; i < 3; i++) step();
        exp = exp_vec(2'd0, 2'd0, 2'd0);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL reset_state: got %b expected %b", act, exp);
        end
    endtask

    // Lock arrives 10 cycles after release: WAIT at edge 4, STABILIZE at 13, RUN at 21.
    task automatic test_bring_up();
        logic [8:0] exp;
        logic [1:0] st;
        rst = 1'b0;
        for (int n = 1; n <= 22; n++) begin
            step();
            if (n < 4)       st = 2'd0;
            else if (n < 13) st = 2'd1;
            else if (n < 21) st = 2'd2;
            else             st = 2'd3;
            exp = exp_vec(st, 2'd0, 2'd0);
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL bring_up edge %0d: got %b expected %b", n, act, exp);
            end
            if (n == 10) pll_locked = 1'b1;
        end
    endtask

    // No lock: 24-cycle retry period, retry_count saturates at 3.
    task automatic test_timeout();
        logic [8:0] exp;
        logic [1:0] st;
        logic [1:0] rc;
        rst        = 1'b1;
        pll_locked = 1'b0;
        step();
        step();
        rst = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            step();
            st  = ((n % 24) < 4) ? 2'd0 : 2'd1;
            rc  = ((n / 24) > 3) ? 2'd3 : 2'((n / 24));
            exp = exp_vec(st, 2'd0, rc);
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL timeout edge %0d: got %b expected %b", n, act, exp);
            end
        end
    endtask

    // One-cycle dropout late in STABILIZE (even at its terminal count) restarts it.
    task automatic test_debounce();
        logic [8:0] exp;
        logic [1:0] st;
        rst = 1'b1;
        step();
        step();
        rst        = 1'b0;
        pll_locked = 1'b1;
        for (int n = 1; n <= 23; n++) begin
            step();
            if (n < 4)        st = 2'd0;
            else if (n == 4)  st = 2'd1;
            else if (n < 13)  st = 2'd2;
            else if (n == 13) st = 2'd1;
            else if (n < 22)  st = 2'd2;
            else              st = 2'd3;
            exp = exp_vec(st, 2'd0, 2'd0);
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL debounce edge %0d: got %b expected %b", n, act, exp);
            end
            if (n == 10) pll_locked = 1'b0;
            if (n == 11) pll_locked = 1'b1;
        end
    endtask

    // Starts in RUN. One-cycle dropout hits RESET_PLL 3 edges later, RUN again at 16.
    // With abort set, rst is raised during STABILIZE and the reset values are checked.
    task automatic test_loss_in_run(input logic [1:0] prev_loss, input logic [1:0] new_loss,
                                    input bit abort_in_stab);
        logic [8:0] exp;
        logic [1:0] st;
        logic [1:0] lc;
        pll_locked = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            step();
            if (n == 1) pll_locked = 1'b1;
            if (n < 3)       st = 2'd3;
            else if (n < 7)  st = 2'd0;
            else if (n == 7) st = 2'd1;
            else if (n < 16) st = 2'd2;
            else             st = 2'd3;
            lc  = (n < 3) ? prev_loss : new_loss;
            exp = exp_vec(st, lc, 2'd0);
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL loss_in_run edge %0d: got %b expected %b", n, act, exp);
            end
            if (abort_in_stab && n == 10) begin
                rst = 1'b1;
                step();
                exp = exp_vec(2'd0, 2'd0, 2'd0);
                n_vec++;
                if (act !== exp) begin
                    n_err++;
                    $display("FAIL reset_mid_op: got %b expected %b", act, exp);
                end
                rst = 1'b0;
                return;
            end
        end
    endtask

    // Immediate lock from release gives RUN at edge 13; then loss_count saturates.
    task automatic test_loss_saturation();
        logic [8:0] exp;
        rst = 1'b1;
        step();
        step();
        rst        = 1'b0;
        pll_locked = 1'b1;
        for (int n = 1; n <= 13; n++) step();
        exp = exp_vec(2'd3, 2'd0, 2'd0);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL quick_bring_up: got %b expected %b", act, exp);
        end
        test_loss_in_run(2'd0, 2'd1, 1'b0);
        test_loss_in_run(2'd1, 2'd2, 1'b0);
        test_loss_in_run(2'd2, 2'd3, 1'b0);
        test_loss_in_run(2'd3, 2'd3, 1'b0);
    endtask

    // Mid-cycle toggles of pll_locked must never move state between edges or produce X.
    task automatic test_sync_isolation();
        logic [1:0] s0;
        int         d;
        logic [8:0] exp;
        for (int c = 0; c < 30; c++) begin
            step();
            s0 = state;
            d  = int'($urandom_range(6, 2));
            #(d) pll_locked = ~pll_locked;
            #(8 - d);
            n_vec++;
            if (state !== s0) begin
                n_err++;
                $display("FAIL sync_state_between_edges cycle %0d: got %b expected %b",
                         c, state, s0);
            end
            n_vec++;
            if ($isunknown(act)) begin
                n_err++;
                $display("FAIL sync_no_x cycle %0d: got %b expected no X", c, act);
            end
        end
        pll_locked = 1'b1;
        for (int i = 0; i < 60 && state !== 2'd3; i++) step();
        exp = exp_vec(2'd3, 2'd3, 2'd0);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL sync_recover: got %b expected %b", act, exp);
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b1;
        pll_locked = 1'b0;
        test_reset();
        test_bring_up();
        test_timeout();
        test_debounce();
        test_loss_in_run(2'd0, 2'd1, 1'b0);
        test_loss_in_run(2'd1, 2'd2, 1'b1);
        test_loss_saturation();
        test_sync_isolation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Sits directly downstream of the 2×125 MHz system PLL.
- Consumes the PLL's asynchronous locked flag and drives the PLL's reset input.
- Produces a debounced system reset and a ready flag for the 125 MHz logic. Those domains re-synchronise the reset locally.
- Runs on the free-running 50 MHz reference clock, so it keeps working while the PLL outputs are stopped or unlocked.
- Retries the PLL on lock timeout and counts lock-loss and retry events for debug.

Parameters:
- PLL_RST_CYCLES, 16: width, in refclk cycles, of each pll_rst pulse.
- LOCK_TIMEOUT_CYCLES, 50000: cycles to wait for lock after a PLL reset before retrying.
- LOCK_STABLE_CYCLES, 1024: consecutive locked cycles required before sys_rst releases.
- CNT_W, 16: width of the internal cycle counter. It must hold max(all three cycle parameters) − 1.
- STAT_W, 8: width of the loss_count and retry_count status counters.

Ports:
- refclk, input, 1: 50 MHz free-running clock. The only clock in the block.
- rst, input, 1: synchronous, active-high reset.
- pll_locked, input, 1: PLL lock flag. Asynchronous to refclk.
- pll_rst, output, 1: reset to the PLL, active high.
- sys_rst, output, 1: system reset for downstream logic, active high.
- ready, output, 1: high only in RUN.
- state, output, 2: current FSM state. 0=RESET_PLL, 1=WAIT_LOCK, 2=STABILIZE, 3=RUN.
- loss_count, output, STAT_W: lock losses seen in RUN. Saturating.
- retry_count, output, STAT_W: lock timeouts. Saturating.

Behaviour:
- Interface: one clock, refclk. Reset is synchronous and active-high, on rst. No other clock or reset input.
- Lock synchroniser:
  - pll_locked passes through a 2-flop synchroniser to give locked_s. Only locked_s is used internally.
  - Both synchroniser flops reset to 0.
- Reset values (rst high on a rising edge): state=RESET_PLL, counter=0, pll_rst=1, sys_rst=1, ready=0, loss_count=0, retry_count=0. rst high mid-operation overrides every transition and produces exactly these values on the next edge.
- All outputs are registered and are a function of the state register plus the counters only.
- Output decode per state:
  - pll_rst=1 only in RESET_PLL.
  - sys_rst=0 only in RUN.
  - ready=1 only in RUN.
- FSM, evaluated each edge with rst=0:
  - RESET_PLL:
    - counter increments each cycle.
    - When counter==PLL_RST_CYCLES−1: go to WAIT_LOCK and clear counter.
    - pll_rst is therefore high for exactly PLL_RST_CYCLES cycles. locked_s is ignored in this state.
  - WAIT_LOCK:
    - If locked_s=1: go to STABILIZE and clear counter.
    - Else if counter==LOCK_TIMEOUT_CYCLES−1: go to RESET_PLL, clear counter, increment retry_count (saturating).
    - Else: increment counter.
  - STABILIZE:
    - If locked_s=0: go to WAIT_LOCK and clear counter. This is a debounce restart, not a loss, so no count changes.
    - Else if counter==LOCK_STABLE_CYCLES−1: go to RUN.
    - Else: increment counter.
  - RUN:
    - If locked_s=0: go to RESET_PLL, clear counter, increment loss_count (saturating).
    - sys_rst rises and ready falls on the same edge the state leaves RUN.
- Timing:
  - Latency from locked_s first high to sys_rst low is LOCK_STABLE_CYCLES+1 edges. That is 1 edge to enter STABILIZE, then LOCK_STABLE_CYCLES cycles in it.
  - Add 2 edges for the synchroniser to measure from pll_locked.
  - A locked_s glitch in RUN of one cycle is sufficient to trigger a loss.
- Saturation:
  - Both status counters stop at 2^STAT_W−1.
  - At saturation they do not wrap, and the FSM behaves normally.
  - Only rst clears them.
- The cycle counter never wraps. Each state leaves at its terminal count, and no count-dependent output exists outside the terminal compare.

Test Plan:
Use PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, STAT_W=2.
1. Normal bring-up:
   - Stimulus: rst high for 3 cycles, then low. pll_locked rises 10 cycles after rst falls.
   - Required: pll_rst high for exactly 4 cycles after rst falls. locked_s goes high 2 edges after pll_locked. sys_rst falls and ready rises 9 edges after locked_s rises. state sequence is 0→1→2→3.
2. Lock timeout and retry:
   - Stimulus: hold pll_locked=0.
   - Required: pll_rst re-pulses every 24 cycles (4 high, 20 low). retry_count steps 1, 2, 3 and then stays at 3 (saturated). sys_rst stays 1 throughout.
3. Debounce restart:
   - Stimulus: lock, then drop pll_locked for 1 cycle after 5 cycles in STABILIZE.
   - Required: state returns to 1, with no pll_rst pulse and no count change. Once lock is steady, the full 8-cycle stabilise is needed before RUN.
4. Loss in RUN:
   - Stimulus: in RUN, drop pll_locked for one cycle.
   - Required: 3 edges later, sys_rst=1, ready=0, pll_rst=1, state=0, and loss_count increments by 1. The FSM then recovers to RUN once lock returns.
5. Reset mid-operation:
   - Stimulus: assert rst during STABILIZE with loss_count=2.
   - Required: on the next edge, every output is at its reset value and both counts are 0.
6. Synchroniser isolation:
   - Stimulus: toggle pll_locked asynchronously mid-cycle.
   - Required: no X on any output, and FSM transitions occur only on refclk edges.
